// File: rtl/alu.sv
// Sixteen-result ALU bank: every cycle the full set of arithmetic, logic and
// shift results of x and y is captured into output registers.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             d,
    output logic             e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] l,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] p
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] sra;
    logic [SHW-1:0]   sh;

    // Extending by one bit makes the top bit of sum the carry and of diff the borrow.
    assign sum  = {1'b0, x} + {1'b0, y};
    assign diff = {1'b0, x} - {1'b0, y};
    assign prod = x * y;
    assign sh   = y[SHW-1:0];
    assign sra  = $unsigned($signed(x) >>> sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            c <= '0;
            d <= 1'b0;
            e <= 1'b0;
            f <= '0;
            g <= '0;
            h <= '0;
            i <= '0;
            j <= '0;
            k <= '0;
            l <= '0;
            m <= '0;
            n <= '0;
            o <= '0;
            p <= '0;
        end else begin
            a <= sum[WIDTH-1:0];
            b <= diff[WIDTH-1:0];
            c <= prod;
            d <= sum[WIDTH];
            e <= diff[WIDTH];
            f <= x & y;
            g <= x | y;
            h <= x ^ y;
            i <= ~x;
            j <= ~(x & y);
            k <= ~(x | y);
            l <= ~(x ^ y);
            m <= x << sh;
            n <= x >> sh;
            o <= sra;
            p <= x + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: integer-arithmetic reference model compared on every falling
// edge, plus literal spot checks, a low-byte sweep and random operands.
module tb_alu;

    typedef struct {
        logic [15:0] a, b, c;
        logic        d, e;
        logic [15:0] f, g, h, i, j, k, l, m, n, o, p;
    } res_t;

    logic        clk, rst;
    logic [15:0] x, y;
    logic [15:0] a, b, c, f, g, h, i, j, k, l, m, n, o, p;
    logic        d, e;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 0;
    res_t exp_r;
    res_t act;

    alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .i(i), .j(j), .k(k), .l(l), .m(m), .n(n), .o(o), .p(p)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference results from plain integer arithmetic on the operand values.
    function automatic res_t model(input int xv, input int yv);
        res_t r;
        int   s, sx, pw, q;
        longint pr;
        s  = yv % 16;
        pw = 1 << s;
        r.a = 16'((xv + yv) % 65536);
        r.d = (xv + yv) >= 65536;
        r.b = 16'((xv - yv + 65536) % 65536);
        r.e = xv < yv;
        pr  = longint'(xv) * longint'(yv);
        r.c = 16'(pr % 65536);
        r.f = 16'(xv) & 16'(yv);
        r.g = 16'(xv) | 16'(yv);
        r.h = 16'(xv) ^ 16'(yv);
        r.i = 16'(65535 - xv);
        r.j = 16'(65535 - int'(r.f));
        r.k = 16'(65535 - int'(r.g));
        r.l = 16'(65535 - int'(r.h));
        r.m = 16'((longint'(xv) * pw) % 65536);
        r.n = 16'(xv / pw);
        sx  = (xv >= 32768) ? xv - 65536 : xv;
        q   = (sx >= 0) ? sx / pw : -((-sx + pw - 1) / pw);
        r.o = 16'((q + 65536) % 65536);
        r.p = 16'((xv + 1) % 65536);
        return r;
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r = model(0, 0);
        r.a = 0; r.b = 0; r.c = 0; r.d = 0; r.e = 0; r.f = 0; r.g = 0; r.h = 0;
        r.i = 0; r.j = 0; r.k = 0; r.l = 0; r.m = 0; r.n = 0; r.o = 0; r.p = 0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_r = zero_res();
        else     exp_r = model(int'(x), int'(y));
    end

    always_comb begin
        act.a = a; act.b = b; act.c = c; act.d = d; act.e = e;
        act.f = f; act.g = g; act.h = h; act.i = i; act.j = j; act.k = k;
        act.l = l; act.m = m; act.n = n; act.o = o; act.p = p;
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s x=%h y=%h got=%h want=%h t=%0t", nm, x, y, got, want, $time);
        end
    endtask

    task automatic chk_all(input res_t r, input res_t w);
        chk("a", r.a, w.a); chk("b", r.b, w.b); chk("c", r.c, w.c);
        chk("d", 16'(r.d), 16'(w.d)); chk("e", 16'(r.e), 16'(w.e));
        chk("f", r.f, w.f); chk("g", r.g, w.g); chk("h", r.h, w.h);
        chk("i", r.i, w.i); chk("j", r.j, w.j); chk("k", r.k, w.k);
        chk("l", r.l, w.l); chk("m", r.m, w.m); chk("n", r.n, w.n);
        chk("o", r.o, w.o); chk("p", r.p, w.p);
    endtask

    always @(negedge clk) if (chk_en) chk_all(act, exp_r);

    task automatic drive(input logic [15:0] xv, input logic [15:0] yv);
        @(posedge clk);
        #1;
        x = xv;
        y = yv;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        x = 16'h1234;
        y = 16'h5678;
        #1;
        chk_all(act, zero_res());
        settle();
        settle();
        chk_all(act, zero_res());
        rst = 0;
        chk_en = 1;
        settle();
        chk("rst_rel_a", a, 16'h68AC);
        chk("rst_rel_b", b, 16'hBBBC);
        chk("rst_rel_d", 16'(d), 16'h0000);
        chk("rst_rel_e", 16'(e), 16'h0001);

        // Async reset while outputs are non-zero.
        #2 rst = 1;
        #1 chk("async_a", a, 16'h0000);
        chk("async_b", b, 16'h0000);
        chk("async_e", 16'(e), 16'h0000);
        #1 rst = 0;

        drive(16'hFFFF, 16'h0001);
        settle();
        chk("wrap_a", a, 16'h0000); chk("wrap_d", 16'(d), 16'h0001);
        chk("wrap_b", b, 16'hFFFE); chk("wrap_e", 16'(e), 16'h0000);
        chk("wrap_p", p, 16'h0000); chk("wrap_c", c, 16'hFFFF);

        drive(16'h0000, 16'h0001);
        settle();
        chk("brw_b", b, 16'hFFFF); chk("brw_e", 16'(e), 16'h0001);
        chk("brw_a", a, 16'h0001); chk("brw_d", 16'(d), 16'h0000);
        chk("brw_i", i, 16'hFFFF); chk("brw_k", k, 16'hFFFE);

        drive(16'h8001, 16'h0004);
        settle();
        chk("sh4_m", m, 16'h0010); chk("sh4_n", n, 16'h0800); chk("sh4_o", o, 16'hF800);

        drive(16'h8001, 16'h0010);
        settle();
        chk("sh0_m", m, 16'h8001); chk("sh0_n", n, 16'h8001); chk("sh0_o", o, 16'h8001);

        drive(16'h00FF, 16'h00FF);
        settle();
        chk("ff_a", a, 16'h01FE); chk("ff_c", c, 16'hFE01); chk("ff_f", f, 16'h00FF);
        chk("ff_h", h, 16'h0000); chk("ff_l", l, 16'hFFFF);

        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 256; yi++) begin
                drive(16'(xi), 16'(yi));
                if (xi == 117 && yi == 40) begin
                    #1 rst = 1;
                    #1 chk("mid_rst_a", a, 16'h0000);
                    chk("mid_rst_m", m, 16'h0000);
                    #1 rst = 0;
                end
            end
        end

        for (int r = 0; r < 3000; r++)
            drive(16'($urandom), 16'($urandom));

        settle();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit combinational ALU bank with registered outputs.
- Every cycle it computes sixteen fixed results from operands x and y in parallel; there is no opcode select.
- Each result has its own output port, and all outputs update together one clock after the operands are sampled.
- It serves as a reference datapath block for arithmetic, logic and shift results.

Parameters:
- WIDTH, 16, operand and result width. All behaviour below is stated for 16; shift amounts use the low log2(WIDTH) bits of y.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  16  operand X, unsigned unless stated.
- y  input  16  operand Y, unsigned unless stated.
- a  output  16  x + y, low 16 bits.
- b  output  16  x - y, two's complement, low 16 bits.
- c  output  16  x * y, low 16 bits of the 32-bit product.
- d  output  1  carry out of x + y (bit 16 of the 17-bit sum).
- e  output  1  borrow of x - y (1 when x < y unsigned).
- f  output  16  x & y.
- g  output  16  x | y.
- h  output  16  x ^ y.
- i  output  16  ~x.
- j  output  16  ~(x & y).
- k  output  16  ~(x | y).
- l  output  16  ~(x ^ y).
- m  output  16  x << y[3:0], logical; zero fill.
- n  output  16  x >> y[3:0], logical; zero fill.
- o  output  16  x >>> y[3:0], arithmetic; fills with x[15].
- p  output  16  x + 1, low 16 bits (increment).

Behaviour:
- Reset:
  - rst high clears all outputs a..p and d, e to 0 immediately, without waiting for a clock.
  - Outputs hold 0 while rst is high.
  - Asserting rst mid-operation discards the pending result.
- Latency:
  - All results are computed combinationally from x, y.
  - They are captured into output registers on the rising edge of clk.
  - Latency is exactly 1 cycle. Throughput is one operand pair per cycle.
  - Outputs change only at a clock edge or on reset.
- No handshake, no state machine. Every output is refreshed every cycle from the x/y values present at that edge.
- Arithmetic:
  - All results are truncated to 16 bits, with no saturation. Wrap-around is required (0xFFFF + 1 = 0x0000, d = 1).
  - d and e are the only status bits. They correspond to the same-cycle a and b.
- Multiply: c = (x * y) mod 2^16; upper product bits are discarded.
- Shifts:
  - Only y[3:0] is used; y[15:4] are ignored for m, n, o.
  - A shift of 0 passes x through unchanged.
  - A shift of 15 leaves one bit (m, n) or sign replication (o).
- Signedness: only o treats x as signed. Everything else is unsigned / bitwise.
- After reset is released, the first valid outputs appear at the first rising clk edge.

Test Plan:
- Reset: rst=1 with x=0x1234, y=0x5678 -> all outputs 0 immediately, and still 0 after clock edges. Release rst -> next edge gives a=0x68AC, b=0xBBBC, d=0, e=1.
- Exhaustive low-byte sweep:
  - Stimulus: x in 0..255, y in 0..255, one pair per clock.
  - Required: each output one cycle later matches a software model for all 16 functions.
  - Check point: x=255, y=255 -> a=0x01FE, c=0xFE01, f=0x00FF, h=0x0000, l=0xFFFF.
- Wrap and carry: x=0xFFFF, y=0x0001 -> a=0x0000, d=1, b=0xFFFE, e=0, p=0x0000, c=0xFFFF.
- Borrow: x=0x0000, y=0x0001 -> b=0xFFFF, e=1, a=0x0001, d=0, i=0xFFFF, k=0xFFFE.
- Shifts, x=0x8001:
  - y=0x0004 -> m=0x0010, n=0x0800, o=0xF800.
  - y=0x0010 (y[3:0]=0) -> m=n=o=0x8001.
- Mid-stream reset: pulse rst between two clock edges while the sweep runs -> outputs go to 0 asynchronously. Next edge after release shows the results of the x/y present at that edge.
